bcd_addsub_serial: RTL

Digit-serial, signed (sign-magnitude) N-digit BCD adder/subtractor. It is the parametrised, clocked successor to the combinational single-digit BCD adder with seven-segment output. It processes one BCD digit per clock, LSD first, and handles subtraction with a nines'/tens' complement pass plus an optional re-complement pass. Result digits feed the existing seven-segment decode, which stays outside this block.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_add.sv | 36 +++
 rtl/bcd_addsub_serial.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the digit-serial BCD adder/subtractor: digit width,
// controller state encoding and small per-digit helper functions.
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_e;

  // Nines' complement of a single decimal digit (only meaningful for 0..9).
  function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] digit);
    return 4'd9 - digit;
  endfunction

  // True when the nibble encodes a legal decimal digit.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// -----------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder: a_i + b_i + cin_i with the +6
// decimal correction.
//   a_i, b_i : BCD digits (0..9)
//   cin_i    : carry in
//   sum_o    : corrected BCD result digit
//   cout_o   : decimal carry out
// -----------------------------------------------------------------------------
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a_i,
  input  logic [BCD_W-1:0] b_i,
  input  logic             cin_i,
  output logic [BCD_W-1:0] sum_o,
  output logic             cout_o
);

  logic [BCD_W:0]   bin_s;
  logic [BCD_W-1:0] adj_s;

  // Binary add, then correct by +6 whenever the result leaves the decimal range.
  always_comb begin
    bin_s = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    adj_s = bin_s[3:0] + 4'd6;
    if (bin_s > 5'd9) begin
      sum_o  = adj_s;
      cout_o = 1'b1;
    end else begin
      sum_o  = bin_s[3:0];
      cout_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// -----------------------------------------------------------------------------
// bcd_addsub_serial
// Digit-serial, sign-magnitude N_DIGITS BCD adder/subtractor, LSD first.
// Effective subtraction is done as A + nines(B) + 1; when that pass yields no
// final carry (|B| > |A|) a second pass tens'-complements the result.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : accepted in IDLE only
//   sub                : 0 = A+B, 1 = A-B
//   a_sign/a_bcd       : operand A (sign, magnitude; digit 0 in [3:0])
//   b_sign/b_bcd       : operand B
//   busy               : operation in progress (ADD/COMP passes)
//   done               : one-cycle completion pulse
//   sum_sign/sum_bcd   : result (held until the next accepted start)
//   overflow           : carry out of the MSD on an effective add
//   invalid            : an operand digit was greater than 9
// -----------------------------------------------------------------------------
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic                      a_sign,
  input  logic [BCD_W*N_DIGITS-1:0] a_bcd,
  input  logic                      b_sign,
  input  logic [BCD_W*N_DIGITS-1:0] b_bcd,
  output logic                      busy,
  output logic                      done,
  output logic                      sum_sign,
  output logic [BCD_W*N_DIGITS-1:0] sum_bcd,
  output logic                      overflow,
  output logic                      invalid
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  state_e                         state_q;
  logic [N_DIGITS-1:0][BCD_W-1:0] a_q;
  logic [N_DIGITS-1:0][BCD_W-1:0] b_q;
  logic [N_DIGITS-1:0][BCD_W-1:0] sum_q;
  logic [IDX_W-1:0]               idx_q;
  logic                           carry_q;
  logic                           eff_sub_q;
  logic                           a_sign_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           sum_sign_q;
  logic                           overflow_q;
  logic                           invalid_q;

  logic [N_DIGITS-1:0][BCD_W-1:0] a_in_s;
  logic [N_DIGITS-1:0][BCD_W-1:0] b_in_s;
  logic                           ops_ok_s;
  logic                           eff_sub_s;
  logic [BCD_W-1:0]               op_a_s;
  logic [BCD_W-1:0]               op_b_s;
  logic [BCD_W-1:0]               dig_sum_s;
  logic                           dig_cout_s;

  assign a_in_s    = a_bcd;
  assign b_in_s    = b_bcd;
  assign eff_sub_s = sub ^ a_sign ^ b_sign;

  // Operand digit check on the live inputs, evaluated at the start edge.
  always_comb begin
    ops_ok_s = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!bcd_valid(a_in_s[k]) || !bcd_valid(b_in_s[k])) begin
        ops_ok_s = 1'b0;
      end else begin
        ops_ok_s = ops_ok_s;
      end
    end
  end

  // Shared adder operand mux: COMP adds the carry onto nines(result digit).
  always_comb begin
    case (state_q)
      COMP: begin
        op_a_s = nines_comp(sum_q[idx_q]);
        op_b_s = 4'd0;
      end
      default: begin
        op_a_s = a_q[idx_q];
        if (eff_sub_q) begin
          op_b_s = nines_comp(b_q[idx_q]);
        end else begin
          op_b_s = b_q[idx_q];
        end
      end
    endcase
  end

  bcd_digit_add u_digit_add (
    .a_i    (op_a_s),
    .b_i    (op_b_s),
    .cin_i  (carry_q),
    .sum_o  (dig_sum_s),
    .cout_o (dig_cout_s)
  );

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      eff_sub_q  <= 1'b0;
      a_sign_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_sign_q <= 1'b0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q        <= a_in_s;
            b_q        <= b_in_s;
            a_sign_q   <= a_sign;
            eff_sub_q  <= eff_sub_s;
            carry_q    <= eff_sub_s;  // the "+1" of the tens' complement of B
            idx_q      <= '0;
            sum_q      <= '0;
            sum_sign_q <= 1'b0;
            overflow_q <= 1'b0;
            if (ops_ok_s) begin
              invalid_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= ADD;
            end else begin
              invalid_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= DONE;
            end
          end else begin
            state_q <= IDLE;
          end
        end

        ADD: begin
          sum_q[idx_q] <= dig_sum_s;
          carry_q      <= dig_cout_s;
          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            if (!eff_sub_q) begin
              sum_sign_q <= a_sign_q;
              overflow_q <= dig_cout_s;
              busy_q     <= 1'b0;
              state_q    <= DONE;
            end else if (dig_cout_s) begin
              // |A| >= |B|: the end-around carry is simply dropped.
              sum_sign_q <= a_sign_q;
              overflow_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= DONE;
            end else begin
              // |A| < |B|: result is in tens' complement form, flip it back.
              carry_q <= 1'b1;
              state_q <= COMP;
            end
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        COMP: begin
          sum_q[idx_q] <= dig_sum_s;
          carry_q      <= dig_cout_s;
          if (idx_q == LAST_IDX) begin
            idx_q      <= '0;
            sum_sign_q <= ~a_sign_q;
            busy_q     <= 1'b0;
            state_q    <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        DONE: begin
          done_q <= 1'b1;
          if (sum_q == '0) begin
            sum_sign_q <= 1'b0;  // no negative zero
          end else begin
            sum_sign_q <= sum_sign_q;
          end
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_sign = sum_sign_q;
  assign sum_bcd  = sum_q;
  assign overflow = overflow_q;
  assign invalid  = invalid_q;

endmodule
